// File: rtl/stage3_packet_messages_counter.sv
// Per-channel message counting with a FWFT queue of packet-messages words {upper16, count}.
// Optional PACKET_SEQ_EN: upper16 carries the channel's packet sequence number (pre-increment).
module stage3_packet_messages_counter #(
    parameter int MSG_W = 16,
    parameter int CH_N  = 4,
    parameter int CH_W  = 2,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  msg_valid,
    input  logic [CH_W-1:0]       msg_channel,
    input  logic                  msg_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MSG_W+15:0]     packet_messages_data,
    output logic [CH_W-1:0]       packet_channel,
    output logic                  drop_flag,
    input  logic                  drop_clear
);
    localparam int WW = MSG_W + 16;

    logic ch_ok, cnt_en, push;
    assign ch_ok  = ({1'b0, msg_channel} < (CH_W+1)'(CH_N));
    assign cnt_en = msg_valid & ch_ok;
    assign push   = cnt_en & msg_last;

    logic [CH_N-1:0][MSG_W-1:0] cnt_q, cnt_d;
    logic [MSG_W-1:0]           cur_cnt, cnt_inc;
    logic [15:0]                upper;

    always_comb begin
        cnt_d   = cnt_q;
        cur_cnt = '0;
        for (int i = 0; i < CH_N; i++)
            if (msg_channel == CH_W'(i)) cur_cnt = cnt_q[i];
        // Saturating increment; this is also the emitted count on the last message
        cnt_inc = (&cur_cnt) ? cur_cnt : cur_cnt + 1'b1;
        for (int i = 0; i < CH_N; i++)
            if (cnt_en && msg_channel == CH_W'(i)) cnt_d[i] = msg_last ? '0 : cnt_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

`ifdef PACKET_SEQ_EN
    logic [CH_N-1:0][15:0] seq_q, seq_d;

    always_comb begin
        seq_d = seq_q;
        upper = '0;
        for (int i = 0; i < CH_N; i++) begin
            if (msg_channel == CH_W'(i)) upper = seq_q[i];
            // Advances even when the push is dropped so the gap is visible downstream
            if (push && msg_channel == CH_W'(i)) seq_d[i] = seq_q[i] + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) seq_q <= '0;
        else     seq_q <= seq_d;
    end
`else
    assign upper = 16'b0;
`endif

    logic [WW-1:0]   mem_data [DEPTH];
    logic [CH_W-1:0] mem_ch   [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]     lvl_q, lvl_d;
    logic            full, pop, accept, drop_q, drop_d;

    assign out_valid = (lvl_q != '0);
    assign full      = (lvl_q == (AW+1)'(DEPTH));
    assign pop       = out_valid & out_ready;
    assign accept    = push & (~full | pop);

    always_comb begin
        wr_d  = accept ? wr_q + 1'b1 : wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;
        lvl_d = lvl_q;
        if (accept && !pop)      lvl_d = lvl_q + 1'b1;
        else if (!accept && pop) lvl_d = lvl_q - 1'b1;
        drop_d = drop_q;
        if (push && !accept) drop_d = 1'b1;
        else if (drop_clear) drop_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            lvl_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            lvl_q  <= lvl_d;
            drop_q <= drop_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_data[wr_q] <= {upper, cnt_inc};
            mem_ch[wr_q]   <= msg_channel;
        end
    end

    assign packet_messages_data = out_valid ? mem_data[rd_q] : '0;
    assign packet_channel       = out_valid ? mem_ch[rd_q]   : '0;
    assign drop_flag            = drop_q;
endmodule

// File: tb/tb_stage3_packet_messages_counter.sv
// Directed plus random bench for stage3_packet_messages_counter against a queue-based packet model.
module tb_stage3_packet_messages_counter;
    localparam int MSG_W = 4;
    localparam int CH_N  = 4;
    localparam int CH_W  = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int CMAX  = (1 << MSG_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              msg_valid = 1'b0;
    logic [CH_W-1:0]   msg_channel = '0;
    logic              msg_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [MSG_W+15:0] packet_messages_data;
    logic [CH_W-1:0]   packet_channel;
    logic              drop_flag;
    logic              drop_clear = 1'b0;

    stage3_packet_messages_counter #(
        .MSG_W(MSG_W), .CH_N(CH_N), .CH_W(CH_W), .DEPTH(DEPTH), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_channel(msg_channel),
        .msg_last(msg_last), .out_valid(out_valid), .out_ready(out_ready),
        .packet_messages_data(packet_messages_data), .packet_channel(packet_channel),
        .drop_flag(drop_flag), .drop_clear(drop_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MSG_W+15:0] data;
        logic [CH_W-1:0]   ch;
    } word_t;

    word_t q[$];
    int    mcnt [CH_N];
    int    mseq [CH_N];
    bit    mdrop;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < CH_N; i++) begin
            mcnt[i] = 0;
            mseq[i] = 0;
        end
        mdrop = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [CH_W-1:0] ch, input logic l,
                              input logic r, input logic c);
        bit    do_pop, do_push, acc;
        int    n;
        word_t w;
        do_pop  = (q.size() != 0) && r;
        do_push = v && l && (int'(ch) < CH_N);
        acc     = do_push && ((q.size() < DEPTH) || do_pop);
        if (do_push && !acc) mdrop = 1'b1;
        else if (c)          mdrop = 1'b0;
        w.data = '0;
        w.ch   = ch;
        if (v && int'(ch) < CH_N) begin
            n = (mcnt[ch] + 1 > CMAX) ? CMAX : mcnt[ch] + 1;
            if (l) begin
`ifdef PACKET_SEQ_EN
                w.data = {16'(mseq[ch]), MSG_W'(n)};
`else
                w.data = {16'd0, MSG_W'(n)};
`endif
                mcnt[ch] = 0;
                mseq[ch] = (mseq[ch] + 1) % 65536;
            end else begin
                mcnt[ch] = n;
            end
        end
        if (do_pop) void'(q.pop_front());
        if (acc)    q.push_back(w);
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("data", 32'(packet_messages_data), 32'(q[0].data));
            chk("channel", 32'(packet_channel), 32'(q[0].ch));
        end
        chk("drop_flag", 32'(drop_flag), 32'(mdrop));
    endtask

    // Called at a falling edge: drive, clock once, update model, check at next falling edge
    task automatic tick(input logic v, input logic [CH_W-1:0] ch, input logic l,
                        input logic r, input logic c);
        msg_valid = v; msg_channel = ch; msg_last = l; out_ready = r; drop_clear = c;
        @(posedge clk);
        model_step(v, ch, l, r, c);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic r, input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, r, 1'b0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(packet_messages_data), 32'd0);
        chk("rst_channel", 32'(packet_channel), 32'd0);
        chk("rst_drop", 32'(drop_flag), 32'd0);
        rst = 1'b0;

        // Single channel, 3 messages then a single-message packet
        tick(1, 0, 0, 1, 0); tick(1, 0, 0, 1, 0); tick(1, 0, 1, 1, 0);
        chk("single_cnt", 32'(packet_messages_data[MSG_W-1:0]), 32'd3);
        tick(1, 0, 1, 1, 0);
        idle(1, 2);

        // Interleaved channels, held then drained in order
        tick(1, 1, 0, 0, 0); tick(1, 2, 0, 0, 0); tick(1, 1, 1, 0, 0);
        tick(1, 2, 0, 0, 0); tick(1, 2, 1, 0, 0);
        chk("ileave_ch", 32'(packet_channel), 32'd1);
        idle(1, 3);

        // Overfill: 5 pushes into depth 4, drain, then one more packet
        for (int i = 0; i < 5; i++) tick(1, 0, 1, 0, 0);
        chk("full_drop", 32'(drop_flag), 32'd1);
        idle(1, 5);
        tick(1, 0, 1, 1, 0);
        idle(1, 2);
        // Set wins over clear, then clear alone
        for (int i = 0; i < 4; i++) tick(1, 3, 1, 0, 0);
        tick(1, 3, 1, 0, 1);
        tick(0, 0, 0, 0, 1);
        chk("drop_cleared", 32'(drop_flag), 32'd0);

        // Full FIFO with pop and push together
        tick(1, 1, 1, 1, 0);
        chk("full_pop_nodrop", 32'(drop_flag), 32'd0);
        idle(1, 5);

        // Saturation on ch3
        for (int i = 0; i < 20; i++) tick(1, 3, 0, 1, 0);
        tick(1, 3, 1, 1, 0);
        chk("sat_cnt", 32'(packet_messages_data[MSG_W-1:0]), 32'(CMAX));
        idle(1, 2);

        // Async reset mid-packet with a word queued
        tick(1, 2, 1, 0, 0); tick(1, 0, 0, 0, 0); tick(1, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 chk("async_rst_valid", 32'(out_valid), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick(1, 0, 1, 1, 0);
        chk("post_rst_cnt", 32'(packet_messages_data[MSG_W-1:0]), 32'd1);
        idle(1, 2);

        // Random traffic
        for (int i = 0; i < 600; i++)
            tick(($urandom % 4) != 0, CH_W'($urandom), ($urandom % 3) == 0,
                 ($urandom % 4) != 0, ($urandom % 16) == 0);
        idle(1, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stage3_packet_messages_counter.md
# stage3_packet_messages_counter

Stage-3 packet message accounting for the market-data feed path. Counts messages per channel across up to `CH_N` interleaved channels. On each packet's last message, builds a packet-messages word and queues it in a small first-word-fall-through FIFO for the downstream stage. The word is `{16-bit upper field, message count}`, with the upper field optionally carrying a per-channel packet sequence number.

## Interface
- `MSG_W`, 16: message count width; equals `message_number_data_bits`.
- `CH_N`, 4: number of channels.
- `CH_W`, 2: channel index width; `2**CH_W >= CH_N`.
- `DEPTH`, 4: output FIFO depth, power of two, ≥ 2.
- `AW`, 2: FIFO address width, `log2(DEPTH)`.
- `clk` in 1: clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `msg_valid` in 1: one message observed this cycle; no backpressure.
- `msg_channel` in `CH_W`: channel of the message; values ≥ `CH_N` are ignored.
- `msg_last` in 1: message closes its channel's current packet; qualified by `msg_valid`.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: downstream accepts head.
- `packet_messages_data` out `MSG_W+16`: head word `{upper16, count}`.
- `packet_channel` out `CH_W`: channel of the head word.
- `drop_flag` out 1: sticky; a completed packet word was lost to a full FIFO.
- `drop_clear` in 1: clears `drop_flag`.

## Operation
- **Per-channel state:** `cnt[ch]` (`MSG_W`) and `seq[ch]` (16 bits); all reset to 0.
- **Non-last message** (`msg_valid & ~msg_last`, valid channel): `cnt[ch] <= sat(cnt[ch]+1)`.
- **Saturation:** `cnt` holds at all-ones and never wraps.
- **Last message** (`msg_valid & msg_last`):
  - `count = sat(cnt[ch]+1)`.
  - `cnt[ch] <= 0`.
  - `seq[ch] <= seq[ch]+1`, mod 2^16, with wrap.
  - Push `{upper16, count}` and `ch` into the FIFO.
- **Dropped packets:** `seq` advances even when the push is dropped, so downstream sees a sequence gap.
- **Packet length:** a single-message packet (`msg_last` on the first message) yields count 1. A count of 0 is never emitted.
- **Invalid channel** (`msg_channel >= CH_N`): no state change, no push.
- **FIFO:**
  - Pop when `out_valid & out_ready`.
  - Push accepted when not full, or when full and a pop occurs in the same cycle.
  - Otherwise the push is dropped and `drop_flag <= 1`.
  - Simultaneous push and pop on an empty FIFO: the pushed word is not visible until the next cycle; the pop is a no-op because `out_valid` = 0.
- **`drop_flag`:**
  - Set has priority over `drop_clear` in the same cycle.
  - `drop_clear` alone sets `drop_flag <= 0` next cycle.
- **Output path:** `packet_messages_data` and `packet_channel` show the FIFO head while `out_valid`. They are held stable while `out_valid & ~out_ready`.

## Timing
- Reset values:
  - Outputs: `out_valid`=0, `packet_messages_data`=0, `packet_channel`=0, `drop_flag`=0.
  - Internal: all `cnt` and `seq` = 0, FIFO pointers = 0.
- Latency: `msg_last` in cycle N → `out_valid`=1 with that word in cycle N+1 (FIFO previously empty).
- Throughput: one packet word per cycle in and one out; full-rate operation sustained with `out_ready` held high.
- Reset mid-operation: state is cleared immediately and asynchronously; partial packet counts and queued words are discarded.
- Reset release: first message is counted on the first rising edge after `rst` deasserts.

## Configuration
- `PACKET_SEQ_EN` defined:
  - `upper16 = seq[ch]`, the value before increment; the first packet of each channel carries seq 0.
- `PACKET_SEQ_EN` undefined:
  - `upper16 = 16'b0`, matching the legacy zero-extended packet-messages format.
  - `seq` registers are not instantiated.
  - Drops are signalled only by `drop_flag`.

## Test plan
- Single channel, with `out_ready`=1:
  - Stimulus: ch0 receives 3 messages, the third with `msg_last`.
  - Response: next cycle `out_valid`=1, count field=3, `packet_channel`=0.
  - With `PACKET_SEQ_EN`: upper16=0, then 1 for the next packet.
- Interleaved channels:
  - Stimulus: ch1, ch2, ch1(last), ch2, ch2(last).
  - Response: words (ch1, count 2) then (ch2, count 3), in that order.
- Backpressure/full:
  - Stimulus: with `out_ready`=0, 5 single-message packets on ch0 (`DEPTH`=4).
  - Response: 4 words queued, `drop_flag`=1.
  - With `PACKET_SEQ_EN`: draining yields seq 0,1,2,3, the next packet carries seq 5, and the count field is 1 for each packet.
- Full with simultaneous pop:
  - Stimulus: FIFO full, `out_ready`=1 and a `msg_last` arrive in the same cycle.
  - Response: push accepted, `drop_flag` stays 0.
- Saturation:
  - Stimulus: with `MSG_W`=4, 20 messages on ch3 then `msg_last`.
  - Response: count field=15.
- Async reset mid-packet:
  - Stimulus: 2 messages on ch0, assert `rst` between clock edges, release, then 1 message with `msg_last`.
  - Response: `out_valid` drops immediately on assertion; the packet after release emits count 1.
